shared_op_arbiter: RTL

- Round-robin arbiter/sequencer that time-shares one two-operand arithmetic unit (add/sub/mul) between num_clients requesters.
- Used by the mesh placer flow when several dataflow nodes of the same op are folded onto one physical PE.
- Each client side uses the async_operator req/ack convention: the client holds req high with operands; the arbiter returns a one-cycle ack with the result.
- One transaction in flight at a time; a three-state FSM sequences grant, execute and respond.

---
 rtl/shared_op_arbiter_pkg.sv | 37 +++
 rtl/shared_op_arbiter_rr_pick_unit.sv | 17 +
 rtl/shared_op_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/shared_op_arbiter_pkg.sv
// Shared types, op encodings and the round-robin pick helper for the shared-operator arbiter.
package shared_op_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_MUL  = 2'd2;
    localparam logic [1:0] OP_NONE = 2'd3;

    localparam int RR_MAX_CLIENTS = 8;

    // First set bit of req_vec at or after ptr, wrapping at n; returns ptr when nothing is set.
    function automatic logic [2:0] rr_pick(input logic [7:0] req_vec, input logic [2:0] ptr, input int n);
        logic [2:0] pick;
        logic [2:0] idx;
        logic       hit;
        pick = ptr;
        idx  = ptr;
        hit  = 1'b0;
        for (int i = 0; i < RR_MAX_CLIENTS; i++) begin
            if (i < n) begin
                if (!hit && req_vec[idx]) begin
                    pick = idx;
                    hit  = 1'b1;
                end
                idx = (int'(idx) == n - 1) ? 3'd0 : idx + 3'd1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/shared_op_arbiter_rr_pick_unit.sv
// Combinational round-robin priority select with a found flag, usable by any shared-resource controller.
module rr_pick_unit
    import shared_op_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_vec,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         found
);

    assign idx   = W'(rr_pick(8'(req_vec), 3'(ptr), N));
    assign found = |req_vec;

endmodule

// File: rtl/shared_op_arbiter.sv
// Round-robin sequencer time-sharing one add/sub/mul unit between req/ack clients.
// Define SHARED_OP_ARB_STATS_EN to add per-client grant counters and a busy-cycle counter.
module shared_op_arbiter
    import shared_op_pkg::*;
#(
    parameter int num_clients = 4,
    parameter int data_width  = 32,
    parameter     op          = "mul",
    parameter int exec_cycles = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [num_clients-1:0]              req,
    input  logic [num_clients*2*data_width-1:0] din,
    output logic [num_clients-1:0]              ack,
    output logic [data_width-1:0]               dout,
    output logic                                busy,
    output logic [$clog2(num_clients)-1:0]      grant_id
`ifdef SHARED_OP_ARB_STATS_EN
    ,
    output logic [num_clients*32-1:0]           grant_count,
    output logic [31:0]                         busy_cycles
`endif
);

    localparam int CW = $clog2(num_clients);
    localparam logic [1:0] OP_CODE = (op == "add") ? OP_ADD :
                                     (op == "sub") ? OP_SUB :
                                     (op == "mul") ? OP_MUL : OP_NONE;
    localparam logic [3:0]             EXEC_LAST   = 4'(exec_cycles - 1);
    localparam logic [CW-1:0]          LAST_CLIENT = CW'(num_clients - 1);
    localparam logic [num_clients-1:0] ONEHOT0     = {{(num_clients-1){1'b0}}, 1'b1};

    logic [data_width-1:0] a_arr [num_clients];
    logic [data_width-1:0] b_arr [num_clients];

    generate
        for (genvar gi = 0; gi < num_clients; gi++) begin : g_unpack
            assign a_arr[gi] = din[2*gi*data_width +: data_width];
            assign b_arr[gi] = din[(2*gi+1)*data_width +: data_width];
        end
    endgenerate

    state_e                 state_q, state_d;
    logic [CW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]          grant_q, grant_d;
    logic [num_clients-1:0] mask_q, mask_d;
    logic [num_clients-1:0] ack_q, ack_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [data_width-1:0]  a_q, a_d, b_q, b_d;
    logic [data_width-1:0]  result_q, result_d;
    logic [data_width-1:0]  dout_q, dout_d;

    logic [num_clients-1:0] eligible;
    logic [num_clients-1:0] grant_onehot;
    logic [CW-1:0]          pick_idx;
    logic                   pick_found;
    logic [data_width-1:0]  alu_res;

    // The one-cycle mask keeps a just-served client from being regranted on stale operands.
    assign eligible     = req & ~mask_q;
    assign grant_onehot = ONEHOT0 << grant_q;

    rr_pick_unit #(
        .N (num_clients),
        .W (CW)
    ) u_pick (
        .req_vec (eligible),
        .ptr     (rr_ptr_q),
        .idx     (pick_idx),
        .found   (pick_found)
    );

    always_comb begin
        case (OP_CODE)
            OP_ADD:  alu_res = a_q + b_q;
            OP_SUB:  alu_res = a_q - b_q;
            OP_MUL:  alu_res = a_q * b_q;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        mask_d   = mask_q;
        ack_d    = '0;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        dout_d   = dout_q;
        case (state_q)
            IDLE: begin
                mask_d = '0;
                cnt_d  = '0;
                if (pick_found) begin
                    a_d     = a_arr[pick_idx];
                    b_d     = b_arr[pick_idx];
                    grant_d = pick_idx;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == EXEC_LAST) begin
                    result_d = alu_res;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                ack_d    = grant_onehot;
                dout_d   = result_q;
                rr_ptr_d = (grant_q == LAST_CLIENT) ? '0 : grant_q + 1'b1;
                mask_d   = grant_onehot;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            mask_q   <= '0;
            ack_q    <= '0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            mask_q   <= mask_d;
            ack_q    <= ack_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            dout_q   <= dout_d;
        end
    end

    assign ack      = ack_q;
    assign dout     = dout_q;
    assign busy     = (state_q != IDLE);
    assign grant_id = grant_q;

`ifdef SHARED_OP_ARB_STATS_EN
    logic [31:0] busy_cnt_q;

    generate
        for (genvar gi = 0; gi < num_clients; gi++) begin : g_stats
            logic [31:0] gcnt_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    gcnt_q <= '0;
                end else if (ack_q[gi] && (gcnt_q != '1)) begin
                    gcnt_q <= gcnt_q + 32'd1;
                end
            end
            assign grant_count[gi*32 +: 32] = gcnt_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_cnt_q <= '0;
        end else if (busy && (busy_cnt_q != '1)) begin
            busy_cnt_q <= busy_cnt_q + 32'd1;
        end
    end

    assign busy_cycles = busy_cnt_q;
`endif

endmodule
